// File: rtl/fir_pkg.sv
// fir_pkg: shared state encoding and arithmetic helpers for the TDM FIR filter.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package fir_pkg;

  // Control states of the time-multiplexed filter.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } fir_state_t;

  // Accumulator width that holds TAPS full-scale unsigned products without wrapping.
  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Clamp an unsigned value to the largest code representable in data_w bits.
  function automatic logic [63:0] sat_clip(input logic [63:0] val, input int data_w);
    logic [63:0] max_v;
    max_v = (64'd1 << data_w) - 64'd1;
    return (val > max_v) ? max_v : val;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// fir_mac: registered unsigned multiply-accumulate with synchronous clear and enable.
// Latency: acc_sum (acc + x*c) is combinational; the accumulator takes it one edge after en.
// Backpressure: none; the caller sequences clear/en.
module fir_mac #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] x,
  input  logic [COEF_W-1:0] c,
  output logic [ACC_W-1:0]  acc_sum
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic [ACC_W-1:0]  acc;
  logic [PROD_W-1:0] prod;

  // Both operands widened to the full product width so the multiply cannot truncate.
  assign prod    = PROD_W'(x) * PROD_W'(c);
  assign acc_sum = acc + ACC_W'(prod);

  // Accumulator: clear wins over enable so every sample starts from zero.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_sum;
    end
  end

endmodule

// File: rtl/fir_filter_tdm.sv
// fir_filter_tdm: programmable unsigned FIR, one shared multiplier, TAPS MAC cycles per sample.
// Latency: sample accepted at edge N -> out_valid after edge N+TAPS; TAPS+2 cycles/sample with out_ready high.
// Backpressure: result held in OUT until out_ready; in_ready is high only in IDLE.
// Build option FIR_ROUND_EN: round half up before the output shift (default: truncate).
module fir_filter_tdm
  import fir_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 8,
  parameter int TAPS      = 4,
  parameter int OUT_SHIFT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     busy
);

  localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
  localparam int AW    = $clog2(TAPS);
  localparam logic [AW-1:0] K_LAST = AW'(TAPS - 1);

  fir_state_t        state;
  logic [AW-1:0]     k;
  logic [COEF_W-1:0] coef [TAPS];
  logic [DATA_W-1:0] hist [TAPS];

  logic              accept;
  logic              mac_en;
  logic [ACC_W-1:0]  acc_final;
  logic [ACC_W:0]    acc_ext;
  logic [ACC_W:0]    acc_rnd;
  logic [ACC_W:0]    acc_scaled;
  logic [DATA_W-1:0] result;

  assign accept = (state == ST_IDLE) && in_valid;
  assign mac_en = (state == ST_MAC);

  // One multiplier walks tap k each MAC cycle; hist[0] is the newest sample.
  fir_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .en      (mac_en),
    .x       (hist[k]),
    .c       (coef[k]),
    .acc_sum (acc_final)
  );

  // One extra bit so the rounding add cannot wrap at full scale.
  assign acc_ext = {1'b0, acc_final};

`ifdef FIR_ROUND_EN
  localparam int RND_POS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  localparam logic [ACC_W:0] RND_ADD = (OUT_SHIFT > 0) ? ((ACC_W+1)'(1) << RND_POS) : '0;
  assign acc_rnd = acc_ext + RND_ADD;
`else
  assign acc_rnd = acc_ext;
`endif

  assign acc_scaled = acc_rnd >> OUT_SHIFT;
  assign result     = DATA_W'(sat_clip(64'(acc_scaled), DATA_W));

  // Coefficient bank: writes land only in IDLE; out-of-range tap indices are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) coef[i] <= '0;
    end else if (coef_we && (state == ST_IDLE) && (int'(coef_addr) < TAPS)) begin
      coef[coef_addr] <= coef_data;
    end
  end

  // Sample history: shifts on each accepted sample and persists across samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) hist[i] <= '0;
    end else if (accept) begin
      hist[0] <= in_data;
      for (int i = 1; i < TAPS; i++) hist[i] <= hist[i-1];
    end
  end

  // Control FSM with registered handshake outputs; the result loads on the last MAC edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      k         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            state    <= ST_MAC;
            k        <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_MAC: begin
          if (k == K_LAST) begin
            state     <= ST_OUT;
            k         <= '0;
            out_valid <= 1'b1;
            out_data  <= result;
          end else begin
            k <= k + AW'(1);
          end
        end
        ST_OUT: begin
          // No accept in the handshake cycle: in_ready rises only on the next edge.
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          k         <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_filter_tdm.sv
// tb_fir_filter_tdm: randomized and directed checks of fir_filter_tdm against a windowed-sum model.
// Latency: measures accept-to-out_valid and accept-to-accept spacing.
// Backpressure: holds out_ready low with a pending sample offered.
module tb_fir_filter_tdm;

  localparam int DATA_W    = 8;
  localparam int COEF_W    = 8;
  localparam int TAPS      = 4;
  localparam int OUT_SHIFT = 8;
  localparam int AW        = $clog2(TAPS);
  localparam longint DMAX  = (longint'(1) << DATA_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              coef_we = 1'b0;
  logic [AW-1:0]     coef_addr = '0;
  logic [COEF_W-1:0] coef_data = '0;
  logic              out_ready = 1'b0;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              busy;

  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  bit     ready_tied = 1'b0;
  int     last_acc = -1;
  longint cf [TAPS];
  int     win [$];
  longint exp_q = 0;

  fir_filter_tdm #(
    .DATA_W    (DATA_W),
    .COEF_W    (COEF_W),
    .TAPS      (TAPS),
    .OUT_SHIFT (OUT_SHIFT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input longint exp);
    total++;
    if (got !== 64'(exp)) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: sum of coef[i] * (i-th most recent sample), optional rounding, shift, clamp.
  function automatic longint model_out();
    longint s = 0;
    for (int i = 0; i < win.size(); i++) s += cf[i] * longint'(win[i]);
`ifdef FIR_ROUND_EN
    if (OUT_SHIFT > 0) s += longint'(1) << (OUT_SHIFT - 1);
`endif
    s = s >> OUT_SHIFT;
    return (s > DMAX) ? DMAX : s;
  endfunction

  function automatic void model_reset();
    win.delete();
    for (int i = 0; i < TAPS; i++) cf[i] = 0;
  endfunction

  function automatic void model_push(input int d);
    win.push_front(d);
    if (win.size() > TAPS) void'(win.pop_back());
    exp_q = model_out();
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int a, input int v);
    coef_we = 1'b1; coef_addr = AW'(a); coef_data = COEF_W'(v);
    step();
    coef_we = 1'b0;
    if (a < TAPS) cf[a] = longint'(v);
  endtask

  // Offer one sample (optionally with a coincident coefficient write) and wait for the accept edge.
  task automatic accept(input int d, input bit we, input int a, input int v);
    int n = 0;
    while (!in_ready && n < 100) begin step(); n++; end
    check("in_ready_wait", 64'(in_ready), 1);
    in_valid = 1'b1; in_data = DATA_W'(d);
    if (we) begin coef_we = 1'b1; coef_addr = AW'(a); coef_data = COEF_W'(v); end
    step();
    in_valid = 1'b0; coef_we = 1'b0;
    if (we && a < TAPS) cf[a] = longint'(v);
    model_push(d);
    if (ready_tied && last_acc >= 0) check("throughput", 64'(cyc - last_acc), TAPS + 2);
    last_acc = cyc;
  endtask

  // Wait for the result, check latency/data, optionally stall and offer a sample, then handshake.
  task automatic collect(input int hold, input bit offer, input int od, input bit mac_wr);
    int n = 0;
    if (mac_wr) begin coef_we = 1'b1; coef_addr = '0; coef_data = 8'h80; end
    while (!out_valid && n < 100) begin step(); coef_we = 1'b0; n++; end
    check("latency", 64'(n), TAPS);
    check("out_data", 64'(out_data), exp_q);
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      if (offer) begin in_valid = 1'b1; in_data = DATA_W'(od); end
      step();
      check("hold_vld", 64'(out_valid), 1);
      check("hold_dat", 64'(out_data), exp_q);
      check("hold_inrdy", 64'(in_ready), 0);
    end
    if (offer) begin in_valid = 1'b1; in_data = DATA_W'(od); end
    out_ready = 1'b1;
    step();
    out_ready = ready_tied;
    check("out_drop", 64'(out_valid), 0);
    check("idle_rdy", 64'(in_ready), 1);
    if (offer) begin
      step();
      in_valid = 1'b0;
      check("late_accept", 64'(busy), 1);
      model_push(od);
      last_acc = -1;
    end
  endtask

  initial begin
    int seen;
    int d;
    model_reset();
    step(); step();
    check("rst_in_ready", 64'(in_ready), 1);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_out_data", 64'(out_data), 0);
    check("rst_busy", 64'(busy), 0);
    reset = 1'b0;
    step();

    // Step response with out_ready tied high.
    write_coef(0, 8'h3C); write_coef(1, 8'h44); write_coef(2, 8'h44); write_coef(3, 8'h3C);
    ready_tied = 1'b1; out_ready = 1'b1; last_acc = -1;
    repeat (5) begin accept(100, 1'b0, 0, 0); collect(0, 1'b0, 0, 1'b0); end
    ready_tied = 1'b0; out_ready = 1'b0;

    // Flush to zero history, then impulse of 200.
    repeat (TAPS) begin accept(0, 1'b0, 0, 0); collect(0, 1'b0, 0, 1'b0); end
    accept(200, 1'b0, 0, 0); collect(0, 1'b0, 0, 1'b0);
    repeat (TAPS) begin accept(0, 1'b0, 0, 0); collect(0, 1'b0, 0, 1'b0); end

    // Saturation at full-scale coefficients and samples.
    for (int i = 0; i < TAPS; i++) write_coef(i, 8'hFF);
    repeat (4) begin accept(255, 1'b0, 0, 0); collect(1, 1'b0, 0, 1'b0); end
    check("sat_last", 64'(out_data), 255);

    // Backpressure: 10-cycle stall with a sample waiting.
    accept(37, 1'b0, 0, 0);
    collect(10, 1'b1, 91, 1'b0);
    collect(0, 1'b0, 0, 1'b0);

    // Coefficient write during MAC is dropped; coincident with accept it is used.
    write_coef(0, 8'h10); write_coef(1, 8'h20); write_coef(2, 8'h30); write_coef(3, 8'h40);
    accept(50, 1'b0, 0, 0); collect(0, 1'b0, 0, 1'b1);
    accept(50, 1'b1, 0, 8'h80); collect(0, 1'b0, 0, 1'b0);

    // Reset during the second MAC cycle.
    accept(120, 1'b0, 0, 0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_reset();
    check("abort_in_ready", 64'(in_ready), 1);
    check("abort_out_valid", 64'(out_valid), 0);
    check("abort_out_data", 64'(out_data), 0);
    check("abort_busy", 64'(busy), 0);
    seen = 0;
    repeat (TAPS + 2) begin step(); if (out_valid) seen++; end
    check("abort_no_vld", 64'(seen), 0);
    accept(77, 1'b0, 0, 0); collect(0, 1'b0, 0, 1'b0);
    check("zero_coef_out", 64'(out_data), 0);
    for (int i = 0; i < TAPS; i++) write_coef(i, 100 + i);
    accept(5, 1'b0, 0, 0); collect(0, 1'b0, 0, 1'b0);

    // Randomized traffic: coefficient updates, coincident writes, stalls, dropped MAC writes.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) write_coef($urandom_range(0, TAPS - 1), $urandom_range(0, 255));
      d = $urandom_range(0, 255);
      if ($urandom_range(0, 4) == 0)
        accept(d, 1'b1, $urandom_range(0, TAPS - 1), $urandom_range(0, 255));
      else
        accept(d, 1'b0, 0, 0);
      collect($urandom_range(0, 3), 1'b0, 0, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
